// File: rtl/iot_event_serialiser.sv
// -----------------------------------------------------------------------------
// iot_event_serialiser
//   Front end for the active-IoT-devices monitor counter. It synchronises
//   N_DEV asynchronous device-status lines, detects on/off transitions per
//   device and serialises them into at most one event per clock. Simultaneous
//   transitions are resolved by a round-robin arbiter.
//
//   Optional feature macro: IOT_FILTER_EN
//     When defined, a per-device stability filter (FILT_CYCLES consecutive
//     cycles) sits between the synchroniser and the edge detector.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst        in   1      asynchronous active-low reset
//   dev_active in   N_DEV  raw device status (1 = on), asynchronous to clk
//   change     out  1      one-cycle pulse: an event is valid this cycle
//   on_off     out  1      event type when change=1 (1 = on, 0 = off)
//   dev_id     out  6      device index of the current/last event
//   busy       out  1      1 while any event is still pending inside the block
// -----------------------------------------------------------------------------
module iot_event_serialiser #(
  parameter int N_DEV       = 8,
  parameter int FILT_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DEV-1:0] dev_active,
  output logic             change,
  output logic             on_off,
  output logic [5:0]       dev_id,
  output logic             busy
);

  localparam int PW = (N_DEV > 1) ? $clog2(N_DEV) : 1;

  // Elaboration-time range checks on the parameters.
  if ((N_DEV < 2) || (N_DEV > 64)) begin : g_bad_n_dev
    $error("iot_event_serialiser: N_DEV out of range 2..64");
  end
  if ((FILT_CYCLES < 1) || (FILT_CYCLES > 15)) begin : g_bad_filt
    $error("iot_event_serialiser: FILT_CYCLES out of range 1..15");
  end

  logic [N_DEV-1:0] s1_r;
  logic [N_DEV-1:0] s2_r;
  logic [N_DEV-1:0] prev_r;
  logic [N_DEV-1:0] pend_on_r;
  logic [N_DEV-1:0] pend_off_r;
  logic [PW-1:0]    ptr_r;

  logic [N_DEV-1:0] level_s;
  logic [N_DEV-1:0] rise_s;
  logic [N_DEV-1:0] fall_s;
  logic [N_DEV-1:0] pend_on_nxt_s;
  logic [N_DEV-1:0] pend_off_nxt_s;
  logic             gnt_vld_s;
  logic [PW-1:0]    gnt_idx_s;
  logic [PW-1:0]    ptr_nxt_s;

  // Two-flop synchroniser for every device line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_r <= '0;
      s2_r <= '0;
    end else begin
      s1_r <= dev_active;
      s2_r <= s1_r;
    end
  end

`ifdef IOT_FILTER_EN
  logic [N_DEV-1:0] filt_r;
  logic [3:0]       cnt_r [N_DEV];

  // Stability filter: accept a new level only after it has persisted for
  // FILT_CYCLES consecutive cycles; any return to the accepted level restarts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_r <= '0;
      for (int i = 0; i < N_DEV; i++) begin
        cnt_r[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < N_DEV; i++) begin
        if (s2_r[i] == filt_r[i]) begin
          cnt_r[i] <= 4'd0;
        end else if (cnt_r[i] == 4'(FILT_CYCLES - 1)) begin
          filt_r[i] <= s2_r[i];
          cnt_r[i]  <= 4'd0;
        end else begin
          cnt_r[i] <= cnt_r[i] + 4'd1;
        end
      end
    end
  end

  assign level_s = filt_r;
`else
  assign level_s = s2_r;
`endif

  assign rise_s = level_s & ~prev_r;
  assign fall_s = ~level_s & prev_r;

  // Round-robin search: first device with any pending bit, starting at ptr.
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_idx_s = '0;
    for (int k = 0; k < N_DEV; k++) begin
      automatic int idx = int'(ptr_r) + k;
      if (idx >= N_DEV) begin
        idx = idx - N_DEV;
      end else begin
        idx = idx;
      end
      if (!gnt_vld_s && (pend_on_r[idx] || pend_off_r[idx])) begin
        gnt_vld_s = 1'b1;
        gnt_idx_s = PW'(idx);
      end else begin
        gnt_vld_s = gnt_vld_s;
      end
    end
  end

  // Next pending state: the grant consumes the old bit first, then this
  // cycle's edges apply to the post-grant state (opposite bit cancels).
  always_comb begin
    pend_on_nxt_s  = pend_on_r;
    pend_off_nxt_s = pend_off_r;
    if (gnt_vld_s) begin
      pend_on_nxt_s[gnt_idx_s]  = 1'b0;
      pend_off_nxt_s[gnt_idx_s] = 1'b0;
    end else begin
      pend_on_nxt_s = pend_on_nxt_s;
    end
    for (int i = 0; i < N_DEV; i++) begin
      if (rise_s[i]) begin
        if (pend_off_nxt_s[i]) begin
          pend_off_nxt_s[i] = 1'b0;
        end else begin
          pend_on_nxt_s[i] = 1'b1;
        end
      end else if (fall_s[i]) begin
        if (pend_on_nxt_s[i]) begin
          pend_on_nxt_s[i] = 1'b0;
        end else begin
          pend_off_nxt_s[i] = 1'b1;
        end
      end else begin
        pend_on_nxt_s[i] = pend_on_nxt_s[i];
      end
    end
  end

  // Pointer advances past the granted device, wrapping modulo N_DEV.
  always_comb begin
    if (!gnt_vld_s) begin
      ptr_nxt_s = ptr_r;
    end else if (gnt_idx_s == PW'(N_DEV - 1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = gnt_idx_s + PW'(1);
    end
  end

  // Edge history, pending bits and arbiter pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_r     <= '0;
      pend_on_r  <= '0;
      pend_off_r <= '0;
      ptr_r      <= '0;
    end else begin
      prev_r     <= level_s;
      pend_on_r  <= pend_on_nxt_s;
      pend_off_r <= pend_off_nxt_s;
      ptr_r      <= ptr_nxt_s;
    end
  end

  // Registered event outputs; busy looks at the post-grant pending state so
  // it drops in the same cycle the last event is presented.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      change <= 1'b0;
      on_off <= 1'b0;
      dev_id <= 6'd0;
      busy   <= 1'b0;
    end else begin
      change <= gnt_vld_s;
      busy   <= |(pend_on_nxt_s | pend_off_nxt_s);
      if (gnt_vld_s) begin
        on_off <= pend_on_r[gnt_idx_s];
        dev_id <= 6'(gnt_idx_s);
      end else begin
        on_off <= on_off;
        dev_id <= dev_id;
      end
    end
  end

endmodule

// File: tb/tb_iot_event_serialiser.sv
// -----------------------------------------------------------------------------
// tb_iot_event_serialiser
//   Directed bench for iot_event_serialiser (N_DEV=8). A behavioural model
//   tracks pending events per device with plain arrays and is compared against
//   the DUT on every falling edge; directed literal checks pin event order,
//   latency, cancellation and reset behaviour.
// -----------------------------------------------------------------------------
module tb_iot_event_serialiser;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dev_active;
  logic       change;
  logic       on_off;
  logic [5:0] dev_id;
  logic       busy;

  int tests = 0;
  int fails = 0;

  iot_event_serialiser #(.N_DEV(N), .FILT_CYCLES(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .dev_active (dev_active),
    .change     (change),
    .on_off     (on_off),
    .dev_id     (dev_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit       model_on;
  bit [7:0] m_samp1, m_samp2, m_seen, m_on, m_off, m_lvl;
  int       m_ptr, m_g, m_d;
  bit       e_change, e_on, e_busy;
  int       e_id;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_samp1 = '0; m_samp2 = '0; m_seen = '0; m_on = '0; m_off = '0;
      m_ptr = 0; e_change = 0; e_on = 0; e_id = 0; e_busy = 0;
    end else begin
      m_lvl = m_samp2;
      m_g = -1;
      for (int k = 0; k < N; k++) begin
        m_d = (m_ptr + k) % N;
        if (m_g < 0 && (m_on[m_d] || m_off[m_d])) m_g = m_d;
      end
      if (m_g >= 0) begin
        e_change = 1; e_on = m_on[m_g]; e_id = m_g;
        m_on[m_g] = 0; m_off[m_g] = 0;
        m_ptr = (m_g + 1) % N;
      end else begin
        e_change = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (m_lvl[i] && !m_seen[i]) begin
          if (m_off[i]) m_off[i] = 0; else m_on[i] = 1;
        end else if (!m_lvl[i] && m_seen[i]) begin
          if (m_on[i]) m_on[i] = 0; else m_off[i] = 1;
        end
      end
      m_seen  = m_lvl;
      m_samp2 = m_samp1;
      m_samp1 = dev_active;
      e_busy  = |(m_on | m_off);
    end
  end

  // ---------------- monitor: compare + event log ----------------
  int ev_id[$];
  bit ev_on[$];
  int ev_cyc[$];
  bit ev_busy[$];
  int cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (model_on) begin
      check("change", 64'(change), 64'(e_change));
      check("busy",   64'(busy),   64'(e_busy));
      check("on_off", 64'(on_off), 64'(e_on));
      check("dev_id", 64'(dev_id), 64'(e_id));
    end
    if (change === 1'b1) begin
      ev_id.push_back(int'(dev_id));
      ev_on.push_back(on_off);
      ev_cyc.push_back(cyc);
      ev_busy.push_back(busy);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    ev_id.delete(); ev_on.delete(); ev_cyc.delete(); ev_busy.delete();
  endtask

  int start_cyc;
  int n_on, n_off, n_dev0;

  initial begin
`ifdef IOT_FILTER_EN
    model_on   = 1'b0;
    rst        = 1'b0;
    dev_active = 8'h00;
    step(2);
    rst = 1'b1;
    step(6);
    clear_log();
    dev_active = 8'h08;
    step(2);
    dev_active = 8'h00;
    step(15);
    check("filt_glitch_count", 64'(ev_id.size()), 64'd0);
    dev_active = 8'h08;
    step(15);
    check("filt_stable_count", 64'(ev_id.size()), 64'd1);
    if (ev_id.size() == 1) begin
      check("filt_stable_id", 64'(ev_id[0]), 64'd3);
      check("filt_stable_on", 64'(ev_on[0]), 64'd1);
    end
`else
    model_on = 1'b1;
    // Test 1: reset with all lines high -> 8 on-events 0..7
    rst        = 1'b0;
    dev_active = 8'hFF;
    #2;
    check("rst_change", 64'(change), 64'd0);
    check("rst_busy",   64'(busy),   64'd0);
    check("rst_dev_id", 64'(dev_id), 64'd0);
    check("rst_on_off", 64'(on_off), 64'd0);
    step(2);
    rst = 1'b1;
    step(20);
    check("t1_count", 64'(ev_id.size()), 64'd8);
    if (ev_id.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        check("t1_id",  64'(ev_id[k]), 64'(k));
        check("t1_on",  64'(ev_on[k]), 64'd1);
        check("t1_gap", 64'(ev_cyc[k] - ev_cyc[0]), 64'(k));
      end
      check("t1_busy_last", 64'(ev_busy[7]), 64'd0);
      check("t1_busy_prev", 64'(ev_busy[6]), 64'd1);
    end
    check("t1_busy_end", 64'(busy), 64'd0);

    // Clear back to all-off
    dev_active = 8'h00;
    step(20);

    // Test 2: single device on, then off, with latency check
    clear_log();
    dev_active = 8'h04;
    start_cyc  = cyc;
    step(12);
    check("t2_on_count", 64'(ev_id.size()), 64'd1);
    if (ev_id.size() == 1) begin
      check("t2_on_id",      64'(ev_id[0]), 64'd2);
      check("t2_on_type",    64'(ev_on[0]), 64'd1);
      check("t2_on_latency", 64'(ev_cyc[0] - start_cyc), 64'd4);
    end
    clear_log();
    dev_active = 8'h00;
    step(12);
    check("t2_off_count", 64'(ev_id.size()), 64'd1);
    if (ev_id.size() == 1) begin
      check("t2_off_id",   64'(ev_id[0]), 64'd2);
      check("t2_off_type", 64'(ev_on[0]), 64'd0);
    end

    // Bring ptr to 1 via a dev0 on/off pair
    dev_active = 8'h01;
    step(12);
    dev_active = 8'h00;
    step(12);

    // Test 3: simultaneous 0 and 7 with ptr=1 -> 7 then 0
    clear_log();
    dev_active = 8'h81;
    step(12);
    check("t3_count", 64'(ev_id.size()), 64'd2);
    if (ev_id.size() == 2) begin
      check("t3_first",  64'(ev_id[0]), 64'd7);
      check("t3_second", 64'(ev_id[1]), 64'd0);
      check("t3_gap",    64'(ev_cyc[1] - ev_cyc[0]), 64'd1);
    end
    dev_active = 8'h00;
    step(12);

    // Test 4: dev0 on for one cycle while devices 1..7 keep arbiter busy
    clear_log();
    dev_active = 8'hFF;
    step(1);
    dev_active = 8'hFE;
    step(20);
    n_on = 0; n_off = 0; n_dev0 = 0;
    foreach (ev_id[k]) begin
      if (ev_on[k]) n_on++; else n_off++;
      if (ev_id[k] == 0) n_dev0++;
    end
    check("t4_dev0_events", 64'(n_dev0), 64'd0);
    check("t4_net_on",      64'(n_on - n_off), 64'd7);
    if (ev_id.size() > 0) check("t4_first_id", 64'(ev_id[0]), 64'd1);
    else check("t4_first_id", 64'hFFFF, 64'd1);

    dev_active = 8'h00;
    step(20);

    // Test 5: async reset while five events pending
    clear_log();
    dev_active = 8'h1F;
    for (int k = 0; k < 10 && busy !== 1'b1; k++) step(1);
    check("t5_busy_before", 64'(busy), 64'd1);
    #1;
    rst = 1'b0;
    #1;
    check("t5_rst_change", 64'(change), 64'd0);
    check("t5_rst_busy",   64'(busy),   64'd0);
    check("t5_rst_events", 64'(ev_id.size()), 64'd0);
    dev_active = 8'h30;
    step(2);
    rst = 1'b1;
    clear_log();
    step(12);
    check("t5_count", 64'(ev_id.size()), 64'd2);
    if (ev_id.size() == 2) begin
      check("t5_id0", 64'(ev_id[0]), 64'd4);
      check("t5_id1", 64'(ev_id[1]), 64'd5);
      check("t5_on0", 64'(ev_on[0]), 64'd1);
      check("t5_on1", 64'(ev_on[1]), 64'd1);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
